// File: rtl/chirp_uart_cmd_rx.sv
// UART command receiver for the chirp generator: 8N1 byte engine plus a 5-byte frame
// parser (SYNC, SF, BW, SYMBOL, CHK) that hands validated configs over valid/ready.
module chirp_uart_cmd_rx #(
    parameter int         CLKS_PER_BIT = 1042,
    parameter int         MAX_SF_WIDTH = 8,
    parameter int         BW_BITWIDTH  = 2,
    parameter int         SF_MIN       = 7,
    parameter int         SF_MAX       = 12,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rx,
    input  logic                    i_cfg_ready,
    output logic                    o_cfg_valid,
    output logic [MAX_SF_WIDTH-1:0] o_sf,
    output logic [BW_BITWIDTH-1:0]  o_bw,
    output logic [7:0]              o_symbol,
    output logic                    o_err_valid,
    output logic [2:0]              o_err_code
);
    // state       | meaning
    // B_IDLE      | line idle, waiting for a low level
    // B_START     | half-bit wait, then confirm start bit
    // B_DATA      | sampling 8 data bits, LSB first
    // B_STOP      | sampling stop bit
    // P_HUNT      | waiting for SYNC_BYTE
    // P_SF/BW/SYM | capturing payload bytes
    // P_CHK       | checking checksum and SF range
    localparam int BIT_CW  = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_CW   = $clog2(TO_CLKS + 1);

    localparam logic [BIT_CW-1:0] HALF_RELOAD = BIT_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CW-1:0] FULL_RELOAD = BIT_CW'(CLKS_PER_BIT - 1);
    localparam logic [TO_CW-1:0]  TO_RELOAD   = TO_CW'(TO_CLKS - 1);
    localparam logic [7:0]        SF_MIN_B    = 8'(SF_MIN);
    localparam logic [7:0]        SF_MAX_B    = 8'(SF_MAX);

    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_START = 2'd1;
    localparam logic [1:0] B_DATA  = 2'd2;
    localparam logic [1:0] B_STOP  = 2'd3;

    localparam logic [2:0] P_HUNT = 3'd0;
    localparam logic [2:0] P_SF   = 3'd1;
    localparam logic [2:0] P_BW   = 3'd2;
    localparam logic [2:0] P_SYM  = 3'd3;
    localparam logic [2:0] P_CHK  = 3'd4;

    localparam logic [2:0] E_FRAMING = 3'b001;
    localparam logic [2:0] E_CHKSUM  = 3'b010;
    localparam logic [2:0] E_SF      = 3'b011;
    localparam logic [2:0] E_TIMEOUT = 3'b100;
    localparam logic [2:0] E_OVERRUN = 3'b101;

    logic              rx_meta;
    logic              rx_sync;
    logic [1:0]        bit_state;
    logic [BIT_CW-1:0] bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              byte_stb;
    logic              frame_err;

    logic [2:0]        p_state;
    logic [TO_CW-1:0]  to_cnt;
    logic [7:0]        sf_sh;
    logic [7:0]        bw_sh;
    logic [7:0]        sym_sh;
    logic              chk_ok;
    logic              sf_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_state <= B_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            case (bit_state)
                B_IDLE: begin
                    if (!rx_sync) begin
                        bit_state <= B_START;
                        bit_cnt   <= HALF_RELOAD;
                    end
                end
                B_START: begin
                    if (bit_cnt == '0) begin
                        if (rx_sync) begin
                            bit_state <= B_IDLE;
                        end else begin
                            bit_state <= B_DATA;
                            bit_cnt   <= FULL_RELOAD;
                            bit_idx   <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                B_DATA: begin
                    if (bit_cnt == '0) begin
                        shift   <= {rx_sync, shift[7:1]};
                        bit_cnt <= FULL_RELOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) bit_state <= B_STOP;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: begin
                    if (bit_cnt == '0) begin
                        bit_state <= B_IDLE;
                        if (rx_sync) byte_stb  <= 1'b1;
                        else         frame_err <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign chk_ok = (shift == (sf_sh ^ bw_sh ^ sym_sh));
    assign sf_ok  = (sf_sh >= SF_MIN_B) && (sf_sh <= SF_MAX_B);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p_state     <= P_HUNT;
            to_cnt      <= TO_RELOAD;
            sf_sh       <= '0;
            bw_sh       <= '0;
            sym_sh      <= '0;
            o_cfg_valid <= 1'b0;
            o_sf        <= '0;
            o_bw        <= '0;
            o_symbol    <= '0;
            o_err_valid <= 1'b0;
            o_err_code  <= '0;
        end else begin
            o_err_valid <= 1'b0;
            if (o_cfg_valid && i_cfg_ready) o_cfg_valid <= 1'b0;

            // Inter-byte silence timer only runs while a frame is in progress
            if (p_state == P_HUNT || byte_stb) to_cnt <= TO_RELOAD;
            else if (to_cnt != '0)             to_cnt <= to_cnt - 1'b1;

            if (frame_err) begin
                p_state     <= P_HUNT;
                o_err_valid <= 1'b1;
                o_err_code  <= E_FRAMING;
            end else if (byte_stb) begin
                case (p_state)
                    P_HUNT: if (shift == SYNC_BYTE) p_state <= P_SF;
                    P_SF: begin
                        sf_sh   <= shift;
                        p_state <= P_BW;
                    end
                    P_BW: begin
                        bw_sh   <= shift;
                        p_state <= P_SYM;
                    end
                    P_SYM: begin
                        sym_sh  <= shift;
                        p_state <= P_CHK;
                    end
                    default: begin
                        p_state <= P_HUNT;
                        if (!chk_ok) begin
                            o_err_valid <= 1'b1;
                            o_err_code  <= E_CHKSUM;
                        end else if (!sf_ok) begin
                            o_err_valid <= 1'b1;
                            o_err_code  <= E_SF;
                        end else if (!o_cfg_valid || i_cfg_ready) begin
                            // A transfer in this same cycle frees the slot for the new frame
                            o_cfg_valid <= 1'b1;
                            o_sf        <= MAX_SF_WIDTH'(sf_sh);
                            o_bw        <= bw_sh[BW_BITWIDTH-1:0];
                            o_symbol    <= sym_sh;
                        end else begin
                            o_err_valid <= 1'b1;
                            o_err_code  <= E_OVERRUN;
                        end
                    end
                endcase
            end else if (p_state != P_HUNT && to_cnt == '0) begin
                p_state     <= P_HUNT;
                o_err_valid <= 1'b1;
                o_err_code  <= E_TIMEOUT;
            end
        end
    end
endmodule

// File: tb/tb_chirp_uart_cmd_rx.sv
// Directed and randomized frames for chirp_uart_cmd_rx, checked against a
// frame-level model of the validation rules and handshake.
module tb_chirp_uart_cmd_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic       cfg_valid;
    logic [7:0] sf;
    logic [1:0] bw;
    logic [7:0] symbol;
    logic       err_valid;
    logic [2:0] err_code;

    always #5 clk = ~clk;

    chirp_uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_cfg_ready(ready),
        .o_cfg_valid(cfg_valid), .o_sf(sf), .o_bw(bw), .o_symbol(symbol),
        .o_err_valid(err_valid), .o_err_code(err_code)
    );

    logic [17:0] xfer_q[$];
    logic [2:0]  err_q[$];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    int          hold_viol = 0;
    logic        prev_hold = 1'b0;
    logic        prev_xfer = 1'b0;
    logic [17:0] prev_cfg = '0;

    // Event recorder: error strobes, accepted transfers, and handshake stability
    always @(negedge clk) begin
        if (!rst) begin
            if (err_valid) err_q.push_back(err_code);
            if (cfg_valid && ready) xfer_q.push_back({sf, bw, symbol});
            if (prev_hold && (!cfg_valid || {sf, bw, symbol} != prev_cfg)) hold_viol++;
            if (prev_xfer && cfg_valid) hold_viol++;
        end
        prev_hold = cfg_valid && !ready;
        prev_xfer = cfg_valid && ready;
        prev_cfg  = {sf, bw, symbol};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] f_sf, input logic [7:0] f_bw,
                              input logic [7:0] f_sym, input logic [7:0] f_chk);
        send_byte(8'hA5);
        send_byte(f_sf);
        send_byte(f_bw);
        send_byte(f_sym);
        send_byte(f_chk);
        tick(4);
    endtask

    task automatic expect_err(input string tag, input logic [2:0] code);
        check({tag, "_nerr"}, err_q.size(), 1);
        if (err_q.size() > 0) check({tag, "_code"}, {29'd0, err_q[0]}, {29'd0, code});
        err_q.delete();
    endtask

    task automatic expect_no_err(input string tag);
        check({tag, "_noerr"}, err_q.size(), 0);
        err_q.delete();
    endtask

    task automatic expect_xfer(input string tag, input logic [7:0] e_sf,
                               input logic [1:0] e_bw, input logic [7:0] e_sym);
        check({tag, "_nxfer"}, xfer_q.size(), 1);
        if (xfer_q.size() > 0) check({tag, "_cfg"}, {14'd0, xfer_q[0]}, {14'd0, e_sf, e_bw, e_sym});
        xfer_q.delete();
    endtask

    task automatic expect_no_xfer(input string tag);
        check({tag, "_noxfer"}, xfer_q.size(), 0);
        xfer_q.delete();
    endtask

    // Frame verdict from the validation rules: 0 accepted, else error code
    function automatic logic [2:0] model_code(input logic [7:0] f_sf, input logic [7:0] f_bw,
                                              input logic [7:0] f_sym, input logic [7:0] f_chk);
        if (f_chk != (f_sf ^ f_bw ^ f_sym)) return 3'b010;
        if (f_sf < 8'd7 || f_sf > 8'd12) return 3'b011;
        return 3'b000;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] f_sf, input logic [7:0] f_bw,
                             input logic [7:0] f_sym, input logic [7:0] f_chk);
        logic [2:0] code;
        code = model_code(f_sf, f_bw, f_sym, f_chk);
        send_frame(f_sf, f_bw, f_sym, f_chk);
        if (code != 3'b000) begin
            expect_err(tag, code);
            expect_no_xfer(tag);
        end else begin
            expect_no_err(tag);
            expect_xfer(tag, f_sf, f_bw[1:0], f_sym);
        end
    endtask

    initial begin
        logic [7:0] r_sf, r_bw, r_sym, r_chk;
        rst = 1'b1;
        rx = 1'b1;
        ready = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(2);
        check("rst_valid", cfg_valid, 0);
        check("rst_sf", sf, 0);
        check("rst_bw", bw, 0);
        check("rst_sym", symbol, 0);
        check("rst_errv", err_valid, 0);
        check("rst_errc", err_code, 0);

        run_frame("basic", 8'h09, 8'h02, 8'h3C, 8'h37);

        ready = 1'b0;
        send_frame(8'h09, 8'h02, 8'h3C, 8'h37);
        check("hold_valid", cfg_valid, 1);
        check("hold_vals", {sf, bw, symbol}, {8'h09, 2'd2, 8'h3C});
        expect_no_err("hold");
        tick(200);
        send_frame(8'h07, 8'h01, 8'h10, 8'h16);
        expect_err("overrun", 3'b101);
        check("ovr_valid", cfg_valid, 1);
        check("ovr_vals", {sf, bw, symbol}, {8'h09, 2'd2, 8'h3C});
        expect_no_xfer("overrun");
        ready = 1'b1;
        tick(1);
        check("ready_drop", cfg_valid, 0);
        expect_xfer("release", 8'h09, 2'd2, 8'h3C);

        run_frame("sf_range", 8'h0D, 8'h00, 8'h00, 8'h0D);
        check("sf_range_valid", cfg_valid, 0);
        run_frame("chksum", 8'h09, 8'h02, 8'h3C, 8'h00);
        run_frame("sf_min", 8'h07, 8'h03, 8'h11, 8'h07 ^ 8'h03 ^ 8'h11);
        run_frame("sf_max", 8'h0C, 8'hFE, 8'h80, 8'h0C ^ 8'hFE ^ 8'h80);
        run_frame("sf_low", 8'h06, 8'h01, 8'h02, 8'h06 ^ 8'h01 ^ 8'h02);

        send_byte(8'hA5);
        send_byte(8'h09);
        send_byte(8'h5A, 1'b0);
        tick(12 * CPB);
        expect_err("framing", 3'b001);
        send_byte(8'h3C);
        send_byte(8'h37);
        tick(4);
        expect_no_err("hunt_after_fe");
        expect_no_xfer("hunt_after_fe");
        run_frame("after_fe", 8'h0B, 8'h01, 8'h44, 8'h0B ^ 8'h01 ^ 8'h44);

        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * CPB);
        expect_no_err("glitch");
        expect_no_xfer("glitch");
        send_byte(8'hA5);
        send_byte(8'h09);
        tick(18 * CPB);
        expect_no_err("pre_timeout");
        tick(4 * CPB);
        expect_err("timeout", 3'b100);
        run_frame("after_to", 8'h09, 8'h02, 8'h3C, 8'h37);

        send_byte(8'hA5);
        send_byte(8'h0A);
        send_byte(8'h01);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rx = 1'b1;
        tick(12 * CPB);
        check("mid_rst_vals", {cfg_valid, sf, bw, symbol}, 0);
        check("mid_rst_err", {err_valid, err_code}, 0);
        expect_no_err("mid_rst");
        expect_no_xfer("mid_rst");
        run_frame("after_rst", 8'h0A, 8'h01, 8'h55, 8'h0A ^ 8'h01 ^ 8'h55);

        for (int k = 0; k < 14; k++) begin
            r_sf  = 8'($urandom_range(5, 14));
            r_bw  = 8'($urandom);
            r_sym = 8'($urandom);
            r_chk = r_sf ^ r_bw ^ r_sym;
            if ($urandom_range(0, 3) == 0) r_chk = r_chk ^ 8'(1 << $urandom_range(0, 7));
            run_frame($sformatf("rand%0d", k), r_sf, r_bw, r_sym, r_chk);
        end

        check("handshake_stable", hold_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/chirp_uart_cmd_rx.md
Name: chirp_uart_cmd_rx

Overview:
Upstream command front-end for the chirp generator. It receives 8N1 UART bytes at 9600 bps from a 10 MHz clock and parses fixed 5-byte frames: SYNC, SF, BW, SYMBOL, CHK. It validates each frame and presents the chirp configuration (spreading factor, bandwidth code, symbol value) on a valid/ready handshake. The chirp generator consumes that configuration; every rejected frame is reported on a one-cycle error strobe.

Parameters:
CLKS_PER_BIT, 1042, clocks per UART bit (10 MHz / 9600); sims override to 16
MAX_SF_WIDTH, 8, width of o_sf
BW_BITWIDTH, 2, width of o_bw
SF_MIN, 7, lowest legal SF
SF_MAX, 12, highest legal SF
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_BITS, 20, bit-times of silence mid-frame before abort

Ports:
i_clk  in  1  system clock, 10 MHz
i_rst  in  1  synchronous reset, active-high
i_rx  in  1  UART RX line, asynchronous, idle high
i_cfg_ready  in  1  chirp generator accepts configuration
o_cfg_valid  out  1  configuration valid, held until accepted
o_sf  out  MAX_SF_WIDTH  spreading factor
o_bw  out  BW_BITWIDTH  bandwidth code
o_symbol  out  8  symbol value (chirp start offset)
o_err_valid  out  1  one-cycle error strobe
o_err_code  out  3  001 framing, 010 checksum, 011 SF range, 100 timeout, 101 overrun

Behaviour:
- Reset: one clock and one reset; the reset is synchronous and active-high. Reset returns all state to idle/HUNT and clears all counters.
- Reset values: o_cfg_valid=0, o_sf=0, o_bw=0, o_symbol=0, o_err_valid=0, o_err_code=0. The synchronizer flops reset to 1.
- Reset mid-byte or mid-frame discards all partial data. No error is raised.
- RX input: i_rx passes through a 2-flop synchronizer. All decisions below use the synchronized signal.
- Bit engine states: IDLE, START, DATA, STOP.
- IDLE -> START: on a synchronized low level.
- START: wait CLKS_PER_BIT/2 clocks (integer division), then resample. High means a false start: return to IDLE with no error. Low: go to DATA.
- DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
- STOP: sample after CLKS_PER_BIT clocks.
  - High: a byte strobe asserts on the next cycle.
  - Low: framing error (001). The byte is discarded and the parser goes to HUNT.
  - In both cases the engine returns to IDLE immediately. It is ready for a new start bit on the cycle after the stop sample.
- Parser states: HUNT, SF, BW, SYM, CHK. Each state advances on a byte strobe.
- HUNT: byte==SYNC_BYTE -> SF. Any other byte: stay in HUNT, no error.
- SF, BW, SYM: latch the byte into shadow registers and advance. BW keeps its low BW_BITWIDTH bits; upper bits are ignored.
- CHK: expected value = SF ^ BW ^ SYM (full 8-bit bytes).
  - Mismatch -> error 010.
  - Else SF outside [SF_MIN, SF_MAX] -> error 011.
  - Checksum takes priority over SF range.
  - Else the frame completes.
  - Always -> HUNT.
- Frame completion:
  - o_cfg_valid=0: on the cycle after the CHK strobe, o_sf/o_bw/o_symbol load from the shadows and o_cfg_valid=1.
  - Outputs remain stable while o_cfg_valid=1.
  - o_cfg_valid && i_cfg_ready: transfer occurs; o_cfg_valid drops next cycle.
  - Completion while o_cfg_valid=1 and i_cfg_ready=0: the new frame is dropped, outputs are unchanged, error 101.
  - Completion in the same cycle as an accepted transfer: the new frame loads and o_cfg_valid stays 1. No overrun.
- Timeout: in SF/BW/SYM/CHK a counter runs and clears on every byte strobe. At TIMEOUT_BITS*CLKS_PER_BIT clocks: error 100 and parser -> HUNT. The counter is idle in HUNT.
- Errors: o_err_valid is high for exactly one cycle with o_err_code valid in that cycle. o_err_code holds its last value otherwise. Framing and timeout cannot coincide.

Test Plan:
1. CLKS_PER_BIT=16, send A5 09 02 3C 37, i_cfg_ready=1 -> o_cfg_valid high 1 cycle with o_sf=9, o_bw=2, o_symbol=0x3C; no error strobe.
2. Same frame with i_cfg_ready=0 for 200 cycles -> o_cfg_valid and values held stable. A second frame A5 07 01 10 16 sent during that time -> error 101, outputs still 9/2/0x3C. Raising ready -> valid drops the next cycle.
3. A5 0D 00 00 0D (SF=13) -> error 011, o_cfg_valid stays 0. A5 09 02 3C 00 -> error 010.
4. Byte with stop bit driven low -> error 001 and parser in HUNT. The next clean frame is accepted.
5. Glitch low for 4 clocks in IDLE -> no byte, no error. Send A5 09 then idle for 20*16 clocks -> error 100, and a following full frame decodes correctly.
6. Assert i_rst for 1 cycle during the DATA bits of SYM -> all outputs 0, and a subsequent frame decodes normally.
